// File: rtl/peri_timer_pkg.sv
// Shared register map, CTRL field layout and payload types for the multi-channel timer.
package peri_timer_pkg;

  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_PER       = 1;
  localparam int unsigned CTRL_IE        = 2;
  localparam int unsigned CTRL_PRESC_LSB = 16;
  localparam int unsigned PRESC_MAX_W    = 16;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  typedef struct packed {
    logic [PRESC_MAX_W-1:0] presc;
    logic                   ie;
    mode_e                  mode;
    logic                   en;
  } ctrl_t;

  // Bus view of CTRL; presc bits above PRESC_W are held at zero by the channel.
  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] word;
    word                                     = '0;
    word[CTRL_EN]                            = c.en;
    word[CTRL_PER]                           = (c.mode == MODE_PERIODIC);
    word[CTRL_IE]                            = c.ie;
    word[CTRL_PRESC_LSB +: PRESC_MAX_W]      = c.presc;
    return word;
  endfunction

endpackage

// File: rtl/peri_timer_mc_timer_channel.sv
// One timer channel: LOAD/CTRL/COUNT registers, prescaler and sticky expiry flag.
module timer_channel
  import peri_timer_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_load,
  input  logic             wr_ctrl,
  input  logic             clr_status,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] count,
  output logic [31:0]      ctrl,
  output logic             expired,
  output logic             irq
);

  ctrl_t              ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]   load_q, load_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               exp_q, exp_d;
  logic               irq_q, irq_d;
  logic               tick;
  logic               unused_wdata;

  assign unused_wdata = ^wdata;

  // Next-state: a LOAD write beats a tick, an expiry beats a W1C in the same cycle.
  always_comb begin
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    tick    = ctrl_q.en && (pc_q == ctrl_q.presc[PRESC_W-1:0]);

    if (wr_load) begin
      pc_d = '0;
    end else if (wr_ctrl && !ctrl_q.en && wdata[CTRL_EN]) begin
      pc_d = '0;
    end else if (ctrl_q.en) begin
      pc_d = tick ? '0 : pc_q + PRESC_W'(1);
    end

    if (wr_ctrl) begin
      ctrl_d                      = '0;
      ctrl_d.en                   = wdata[CTRL_EN];
      ctrl_d.mode                 = mode_e'(wdata[CTRL_PER]);
      ctrl_d.ie                   = wdata[CTRL_IE];
      ctrl_d.presc[PRESC_W-1:0]   = wdata[CTRL_PRESC_LSB +: PRESC_W];
    end

    if (clr_status && wdata[0]) begin
      exp_d = 1'b0;
    end

    if (wr_load) begin
      load_d  = wdata[WIDTH-1:0];
      count_d = wdata[WIDTH-1:0];
    end else if (tick && (count_q != '0)) begin
      if (count_q == WIDTH'(1)) begin
        exp_d   = 1'b1;
        count_d = (ctrl_q.mode == MODE_PERIODIC) ? load_q : '0;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end

    irq_d = exp_d && ctrl_d.ie;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      pc_q    <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      irq_q   <= irq_d;
    end
  end

  assign load    = load_q;
  assign count   = count_q;
  assign ctrl    = ctrl_to_word(ctrl_q);
  assign expired = exp_q;
  assign irq     = irq_q;

endmodule

// File: rtl/peri_timer_mc.sv
// Multi-channel down-counting timer on a word-addressed peripheral bus.
module peri_timer_mc
  import peri_timer_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              irq_o,
  output logic [N_CH-1:0]   expired_o
);

  localparam int unsigned CH_W = ADDR_W - 2;

  logic [CH_W-1:0]  ch_sel;
  logic [1:0]       reg_sel;
  logic [WIDTH-1:0] load_a  [N_CH];
  logic [WIDTH-1:0] count_a [N_CH];
  logic [31:0]      ctrl_a  [N_CH];
  logic [N_CH-1:0]  irq_v;

  assign ch_sel  = addr_i[ADDR_W-1:2];
  assign reg_sel = addr_i[1:0];

  // Out-of-range channel indices match no instance, so their writes fall away.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    assign hit = we_i && (ch_sel == CH_W'(i));

    timer_channel #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk        (clk_i),
      .rst        (rst_i),
      .wr_load    (hit && (reg_sel == REG_LOAD)),
      .wr_ctrl    (hit && (reg_sel == REG_CTRL)),
      .clr_status (hit && (reg_sel == REG_STATUS)),
      .wdata      (data_i),
      .load       (load_a[i]),
      .count      (count_a[i]),
      .ctrl       (ctrl_a[i]),
      .expired    (expired_o[i]),
      .irq        (irq_v[i])
    );
  end

  // Read mux; unmatched channels and unused bits read as zero.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (reg_sel)
          REG_LOAD:  data_o = 32'(load_a[i]);
          REG_CTRL:  data_o = ctrl_a[i];
          REG_COUNT: data_o = 32'(count_a[i]);
          default:   data_o = {31'b0, expired_o[i]};
        endcase
      end
    end
  end

  assign irq_o = |irq_v;

endmodule
